hue_sequencer: RTL

- Upstream stage of the RGB LED path.
- Generates three duty-cycle values (R, G, B) that walk the full hue wheel through six linear ramp phases.
- Each value feeds one per-channel PWM generator. That generator drives an active-low LED pin.
- Replaces the fixed fade pattern with a paced, pausable, phase-observable sequencer.

---
 rtl/hue_seq_pkg.sv | 46 ++++
 rtl/hue_sequencer_tick_divider.sv | 46 ++++
 rtl/hue_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hue_seq_pkg.sv
// Shared types and the channel-mapping helper for the hue wheel sequencer.
// Latency: none (types and a pure function).
// Backpressure: none.
package hue_seq_pkg;

    localparam int NUM_PHASES = 6;

    // Six ramp phases. Each name gives the pair of channels involved and
    // whether the moving channel rises or falls.
    typedef enum logic [2:0] {
        PH_RG_UP = 3'd0,   // R full, G rising
        PH_RG_DN = 3'd1,   // G full, R falling
        PH_GB_UP = 3'd2,   // G full, B rising
        PH_GB_DN = 3'd3,   // B full, G falling
        PH_BR_UP = 3'd4,   // B full, R rising
        PH_BR_DN = 3'd5    // R full, B falling
    } phase_t;

    // The function works at a fixed 32-bit width; callers keep the low bits.
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
    } rgb_t;

    // Map a phase and ramp position to the three channel duty values.
    function automatic rgb_t map_rgb(phase_t ph, logic [31:0] ramp, logic [31:0] max_v);
        rgb_t        o;
        logic [31:0] rise;
        logic [31:0] fall;
        rise = ramp;
        fall = max_v - ramp;
        o    = '0;
        case (ph)
            PH_RG_UP: begin o.r = max_v; o.g = rise;  o.b = '0;    end
            PH_RG_DN: begin o.r = fall;  o.g = max_v; o.b = '0;    end
            PH_GB_UP: begin o.r = '0;    o.g = max_v; o.b = rise;  end
            PH_GB_DN: begin o.r = '0;    o.g = fall;  o.b = max_v; end
            PH_BR_UP: begin o.r = rise;  o.g = '0;    o.b = max_v; end
            PH_BR_DN: begin o.r = max_v; o.g = '0;    o.b = fall;  end
            default:  begin o.r = max_v; o.g = '0;    o.b = '0;    end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/hue_sequencer_tick_divider.sv
// Strobe generator: one-cycle tick every TICK_CYCLES enabled clocks.
// Latency: tick is combinational from the count register and en.
// Backpressure: en=0 freezes the count; the partial interval resumes later.
module tick_divider #(
    parameter int TICK_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    if (TICK_CYCLES < 1) begin : g_bad_tick
        $error("tick_divider: TICK_CYCLES must be at least 1");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count while enabled; the terminal count raises tick and wraps.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// Hue wheel sequencer: paced R/G/B duty ramps through six phases. Optional macro HUE_SEQ_GAMMA_EN adds a square-law stage.
// Latency: outputs change 1 cycle after a tick (2 cycles with HUE_SEQ_GAMMA_EN).
// Backpressure: en=0 holds all sequencing state and suppresses phase_adv.
module hue_sequencer
    import hue_seq_pkg::*;
#(
    parameter  int PWM_INTERVAL = 1200,
    parameter  int TICK_CYCLES  = 60000,
    parameter  int N_STEPS      = 100,
    localparam int W            = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] pwm_valueR,
    output logic [W-1:0] pwm_valueG,
    output logic [W-1:0] pwm_valueB,
    output logic [2:0]   phase,
    output logic         phase_adv
);

    localparam int FULL_SCALE = (1 << W) - 1;
    localparam int MAX_DUTY   = (PWM_INTERVAL < FULL_SCALE) ? PWM_INTERVAL : FULL_SCALE;
    localparam int INC        = (N_STEPS > 0) ? (MAX_DUTY / N_STEPS) : 0;
    localparam int SW         = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    localparam logic [W-1:0]  MAX_W     = W'(MAX_DUTY);
    localparam logic [W-1:0]  INC_W     = W'(INC);
    localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);

    if (INC == 0) begin : g_bad_inc
        $error("hue_sequencer: MAX_DUTY / N_STEPS must be non-zero");
    end

    logic tick;

    tick_divider #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    logic [SW-1:0] step_q,  step_d;
    logic [W-1:0]  ramp_q,  ramp_d;
    phase_t        phase_q, phase_d;
    logic          adv_q,   adv_d;
    logic [W-1:0]  r_q, g_q, b_q;
    rgb_t          rgb_d;

    // Step/ramp/phase advance on each tick; outputs are mapped from the
    // next state so they land in the same register update as the state.
    always_comb begin
        step_d  = step_q;
        ramp_d  = ramp_q;
        phase_d = phase_q;
        adv_d   = 1'b0;
        if (tick) begin
            if (step_q == LAST_STEP) begin
                step_d  = '0;
                ramp_d  = '0;
                adv_d   = 1'b1;
                phase_d = (phase_q == PH_BR_DN) ? PH_RG_UP : phase_t'(phase_q + 3'd1);
            end else begin
                step_d = step_q + 1'b1;
                ramp_d = (ramp_q > (MAX_W - INC_W)) ? MAX_W : (ramp_q + INC_W);
            end
        end
        rgb_d = map_rgb(phase_d, 32'(ramp_d), 32'(MAX_DUTY));
    end

    // Sequencing state and linear output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q  <= '0;
            ramp_q  <= '0;
            phase_q <= PH_RG_UP;
            adv_q   <= 1'b0;
            r_q     <= MAX_W;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            step_q  <= step_d;
            ramp_q  <= ramp_d;
            phase_q <= phase_d;
            adv_q   <= adv_d;
            r_q     <= rgb_d.r[W-1:0];
            g_q     <= rgb_d.g[W-1:0];
            b_q     <= rgb_d.b[W-1:0];
        end
    end

    // Mapped values never exceed MAX_DUTY, so the upper bits are always zero.
    logic unused_rgb_hi;
    assign unused_rgb_hi = ^{rgb_d.r[31:W], rgb_d.g[31:W], rgb_d.b[31:W]};

`ifdef HUE_SEQ_GAMMA_EN
    localparam logic [2*W-1:0] MAX_SQ = (2*W)'(longint'(MAX_DUTY) * longint'(MAX_DUTY));

    logic [2*W-1:0] r_sq, g_sq, b_sq;
    logic [W-1:0]   r2_q, g2_q, b2_q;
    phase_t         phase2_q;
    logic           adv2_q;

    assign r_sq = {{W{1'b0}}, r_q} * {{W{1'b0}}, r_q};
    assign g_sq = {{W{1'b0}}, g_q} * {{W{1'b0}}, g_q};
    assign b_sq = {{W{1'b0}}, b_q} * {{W{1'b0}}, b_q};

    // Square-law stage; phase and its pulse ride along to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_q     <= MAX_SQ[2*W-1:W];
            g2_q     <= '0;
            b2_q     <= '0;
            phase2_q <= PH_RG_UP;
            adv2_q   <= 1'b0;
        end else begin
            r2_q     <= r_sq[2*W-1:W];
            g2_q     <= g_sq[2*W-1:W];
            b2_q     <= b_sq[2*W-1:W];
            phase2_q <= phase_q;
            adv2_q   <= adv_q;
        end
    end

    // The >>W drops the low half of each product.
    logic unused_sq_lo;
    assign unused_sq_lo = ^{r_sq[W-1:0], g_sq[W-1:0], b_sq[W-1:0], MAX_SQ[W-1:0]};

    assign pwm_valueR = r2_q;
    assign pwm_valueG = g2_q;
    assign pwm_valueB = b2_q;
    assign phase      = phase2_q;
    assign phase_adv  = adv2_q;
`else
    assign pwm_valueR = r_q;
    assign pwm_valueG = g_q;
    assign pwm_valueB = b_q;
    assign phase      = phase_q;
    assign phase_adv  = adv_q;
`endif

endmodule
